dataflow_deadlock_monitor: RTL and testbench
============================================

Name: dataflow_deadlock_monitor

Overview:
- Parametrised runtime deadlock/stall monitor for a linear chain of NUM_PROC dataflow processes connected by FIFO channels (e.g. pixel reader -> gradients -> cells -> SVM).
- Takes per-process "blocked on input empty" / "blocked on output full" flags. Detects adjacent-pair wait cycles and whole-chain stalls that persist for a programmable number of cycles.
- Latches a diagnostic record until software clears it.
- Instantiated next to the dataflow region for both simulation and on-FPGA debug.

Parameters:
- NUM_PROC, 4, number of processes in the chain (>=2).
- CNT_W, 16, width of the persistence counter and threshold.
- TS_W, 32, width of the free-running cycle timestamp.
- IDX_W, 2, width of the origin index (>= clog2(NUM_PROC-1), min 1).

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  monitoring enable.
- clear  in  1  single-cycle pulse: drop latched record, restart monitoring.
- threshold  in  CNT_W  persistence cycles required; 0 is treated as 1.
- blk_in  in  NUM_PROC  bit i: process i stalled on an empty input channel.
- blk_out  in  NUM_PROC  bit i: process i stalled on a full output channel.
- dl_detect  out  1  sticky detection flag.
- dl_kind  out  2  01 = pair deadlock, 10 = global stall, 00 = none.
- dl_mask  out  NUM_PROC-1  pair mask captured at detection.
- dl_origin  out  IDX_W  lowest set bit of dl_mask; 0 for global stall.
- dl_time  out  TS_W  timestamp value at detection.
- state  out  2  00 IDLE, 01 ARMED, 10 DETECTED.

Behaviour:
- Reset: all outputs 0, both counters 0, timestamp 0, state IDLE.
- Timestamp increments every cycle from reset and wraps at 2^TS_W.
- pair_mask[i] = blk_out[i] & blk_in[i+1], for i = 0..NUM_PROC-2 (combinational).
- all_blk = AND over i of (blk_in[i] | blk_out[i]).
- Pair counter pc:
  - Increments (saturating at 2^CNT_W-1) when pair_mask != 0 and pair_mask == its previous-cycle register.
  - Loads 1 when pair_mask != 0 and differs from the previous cycle.
  - Loads 0 when pair_mask == 0.
- Global counter gc: increments (saturating) while all_blk; 0 otherwise.
- FSM:
  - IDLE: if enable and (pair_mask != 0 or all_blk), go to ARMED.
  - ARMED:
    - if !enable, or neither condition holds -> IDLE, counters 0.
    - if pc reaches threshold -> DETECTED, kind 01.
    - else if gc reaches threshold -> DETECTED, kind 10.
    - Pair takes priority when both reach threshold on the same edge.
  - DETECTED: holds all dl_* outputs. Counters frozen at 0. enable is ignored. Leaves only on clear.
- Latency: the condition must be sampled at threshold consecutive rising edges. dl_detect is registered high after the threshold-th edge. threshold = 1 gives detection on the first sampling edge.
- On entering DETECTED, capture in the same edge: dl_mask = pair_mask, dl_origin, dl_time = current timestamp. Kind 10 captures dl_mask = 0.
- clear:
  - In any state, on the next edge: state IDLE, counters 0, dl_* outputs 0.
  - clear wins over a simultaneous detection.
  - If the condition persists, re-detection occurs threshold cycles after clear is deasserted.
- enable low outside DETECTED: counters 0, state IDLE.
- A mid-operation reset is asynchronous: it clears everything immediately, with no dependence on clock.
- Changing the threshold while ARMED takes effect at the next comparison. A threshold at or below the current count triggers detection at the next edge.

Test Plan:
- Reset mid-ARMED (pc=5) -> all outputs 0 immediately, state 00.
- NUM_PROC=4, threshold=8, blk_out=0010, blk_in=0100 held 8 edges -> dl_detect=1, kind=01, mask=010, origin=1, dl_time = timestamp at the 8th edge.
- Same stimulus but the mask toggles to 001 at edge 5, then holds -> pc restarts at 1; detection 8 edges after the toggle with mask=001, origin=0.
- All four processes blocked, no pair (blk_in=1111, blk_out=0000), threshold=3 -> kind=10, mask=000 after 3 edges. Pair and global reaching threshold on the same edge -> kind=01.
- DETECTED with the condition still held: clear pulse -> outputs 0 next edge; re-detect exactly threshold edges later. clear coincident with the detecting edge -> no detection.
- enable=0 with the pair condition held for 100 cycles -> state stays IDLE, dl_detect stays 0. threshold=0 -> behaves as 1.

Source files
------------

// File: rtl/dataflow_deadlock_monitor.sv
// Runtime stall/deadlock watchdog for a linear chain of dataflow processes.
// Flags adjacent producer/consumer wait pairs or whole-chain stalls that persist, and latches a record.
module dataflow_deadlock_monitor #(
    parameter int NUM_PROC = 4,
    parameter int CNT_W    = 16,
    parameter int TS_W     = 32,
    parameter int IDX_W    = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                clear_i,
    input  logic [CNT_W-1:0]    threshold_i,
    input  logic [NUM_PROC-1:0] blk_in_i,
    input  logic [NUM_PROC-1:0] blk_out_i,
    output logic                dl_detect_o,
    output logic [1:0]          dl_kind_o,
    output logic [NUM_PROC-2:0] dl_mask_o,
    output logic [IDX_W-1:0]    dl_origin_o,
    output logic [TS_W-1:0]     dl_time_o,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_DET   = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state_q;
    logic [CNT_W-1:0]    pc_q, gc_q;
    logic [CNT_W-1:0]    pc_d, gc_d;
    logic [NUM_PROC-2:0] pm_q;
    logic [TS_W-1:0]     ts_q;
    logic                dl_detect_q;
    logic [1:0]          dl_kind_q;
    logic [NUM_PROC-2:0] dl_mask_q;
    logic [IDX_W-1:0]    dl_origin_q;
    logic [TS_W-1:0]     dl_time_q;

    logic [NUM_PROC-2:0] pair_mask;
    logic [NUM_PROC-1:0] proc_blk;
    logic                all_blk;
    logic                active;
    logic                pair_hit;
    logic                global_hit;
    logic [CNT_W-1:0]    thr_eff;
    logic [IDX_W-1:0]    origin_d;

    // Process i waits on a full output while its consumer i+1 waits on an empty input.
    generate
        for (genvar gi = 0; gi < NUM_PROC - 1; gi++) begin : g_pair
            assign pair_mask[gi] = blk_out_i[gi] & blk_in_i[gi+1];
        end
        for (genvar gi = 0; gi < NUM_PROC; gi++) begin : g_blk
            assign proc_blk[gi] = blk_in_i[gi] | blk_out_i[gi];
        end
    endgenerate

    assign all_blk = &proc_blk;
    assign thr_eff = (threshold_i == '0) ? CNT_W'(1) : threshold_i;
    assign active  = enable_i && (state_q != ST_DET);

    always_comb begin
        pc_d = '0;
        if (active && (pair_mask != '0)) begin
            if (pair_mask != pm_q) begin
                pc_d = CNT_W'(1);
            end else if (pc_q == CNT_MAX) begin
                pc_d = pc_q;
            end else begin
                pc_d = pc_q + 1'b1;
            end
        end
    end

    always_comb begin
        gc_d = '0;
        if (active && all_blk) begin
            gc_d = (gc_q == CNT_MAX) ? gc_q : gc_q + 1'b1;
        end
    end

    // Comparing the post-edge count makes threshold N fire on the N-th sampling edge.
    assign pair_hit   = active && (pc_d >= thr_eff);
    assign global_hit = active && (gc_d >= thr_eff);

    always_comb begin
        origin_d = '0;
        for (int i = NUM_PROC - 2; i >= 0; i--) begin
            if (pair_mask[i]) begin
                origin_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            gc_q        <= '0;
            pm_q        <= '0;
            ts_q        <= '0;
            dl_detect_q <= 1'b0;
            dl_kind_q   <= 2'b00;
            dl_mask_q   <= '0;
            dl_origin_q <= '0;
            dl_time_q   <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
            if (clear_i) begin
                state_q     <= ST_IDLE;
                pc_q        <= '0;
                gc_q        <= '0;
                pm_q        <= '0;
                dl_detect_q <= 1'b0;
                dl_kind_q   <= 2'b00;
                dl_mask_q   <= '0;
                dl_origin_q <= '0;
                dl_time_q   <= '0;
            end else begin
                case (state_q)
                    ST_DET: begin
                        pc_q <= '0;
                        gc_q <= '0;
                        pm_q <= '0;
                    end
                    default: begin
                        pm_q <= active ? pair_mask : '0;
                        if (pair_hit) begin
                            state_q     <= ST_DET;
                            pc_q        <= '0;
                            gc_q        <= '0;
                            dl_detect_q <= 1'b1;
                            dl_kind_q   <= 2'b01;
                            dl_mask_q   <= pair_mask;
                            dl_origin_q <= origin_d;
                            dl_time_q   <= ts_q;
                        end else if (global_hit) begin
                            state_q     <= ST_DET;
                            pc_q        <= '0;
                            gc_q        <= '0;
                            dl_detect_q <= 1'b1;
                            dl_kind_q   <= 2'b10;
                            dl_mask_q   <= '0;
                            dl_origin_q <= '0;
                            dl_time_q   <= ts_q;
                        end else begin
                            pc_q    <= pc_d;
                            gc_q    <= gc_d;
                            state_q <= (active && ((pair_mask != '0) || all_blk)) ? ST_ARMED : ST_IDLE;
                        end
                    end
                endcase
            end
        end
    end

    assign dl_detect_o = dl_detect_q;
    assign dl_kind_o   = dl_kind_q;
    assign dl_mask_o   = dl_mask_q;
    assign dl_origin_o = dl_origin_q;
    assign dl_time_o   = dl_time_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dataflow_deadlock_monitor.sv
// Directed bench for dataflow_deadlock_monitor with the default 4-process configuration.
module tb_dataflow_deadlock_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        clear;
    logic [15:0] threshold;
    logic [3:0]  blk_in;
    logic [3:0]  blk_out;
    logic        dl_detect;
    logic [1:0]  dl_kind;
    logic [2:0]  dl_mask;
    logic [1:0]  dl_origin;
    logic [31:0] dl_time;
    logic [1:0]  state;

    int passed = 0;
    int total  = 0;
    logic [31:0] cyc;
    logic [31:0] t_exp;

    dataflow_deadlock_monitor #(
        .NUM_PROC(4), .CNT_W(16), .TS_W(32), .IDX_W(2)
    ) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .clear_i(clear),
        .threshold_i(threshold), .blk_in_i(blk_in), .blk_out_i(blk_out),
        .dl_detect_o(dl_detect), .dl_kind_o(dl_kind), .dl_mask_o(dl_mask),
        .dl_origin_o(dl_origin), .dl_time_o(dl_time), .state_o(state)
    );

    always #5 clk = ~clk;

    // Independent edge counter mirroring what the timestamp should read.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 32'd0;
        else     cyc <= cyc + 32'd1;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        total++; if ({dl_detect, dl_kind, dl_mask, dl_origin, dl_time, state} !== 42'd0)
            $display("FAIL reset_outputs got=%h want=0", {dl_detect, dl_kind, dl_mask, dl_origin, dl_time, state}); else passed++;
        rst = 1'b0;
        enable = 1'b1; threshold = 16'd8; blk_out = 4'b0010; blk_in = 4'b0100;
        step(5);
        total++; if (state !== 2'b01) $display("FAIL armed_before_reset got=%b want=01", state); else passed++;
        #2 rst = 1'b1;
        #1;
        total++; if (state !== 2'b00) $display("FAIL async_reset_state got=%b want=00", state); else passed++;
        total++; if ({dl_detect, dl_kind, dl_mask, dl_origin, dl_time} !== 40'd0)
            $display("FAIL async_reset_outputs got=%h want=0", {dl_detect, dl_kind, dl_mask, dl_origin, dl_time}); else passed++;
        $display("reset: state=%b detect=%b", state, dl_detect);
        blk_out = 4'b0000; blk_in = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        step(2);
    endtask

    task automatic test_pair_detect();
        threshold = 16'd8; blk_out = 4'b0010; blk_in = 4'b0100;
        for (int k = 1; k <= 8; k++) begin
            if (k == 8) t_exp = cyc;
            @(negedge clk);
            if (k == 7) begin
                total++; if (dl_detect !== 1'b0) $display("FAIL pair_early got=%b want=0", dl_detect); else passed++;
            end
        end
        total++; if (dl_detect !== 1'b1) $display("FAIL pair_detect got=%b want=1", dl_detect); else passed++;
        total++; if (dl_kind !== 2'b01) $display("FAIL pair_kind got=%b want=01", dl_kind); else passed++;
        total++; if (dl_mask !== 3'b010) $display("FAIL pair_mask got=%b want=010", dl_mask); else passed++;
        total++; if (dl_origin !== 2'd1) $display("FAIL pair_origin got=%0d want=1", dl_origin); else passed++;
        total++; if (dl_time !== t_exp) $display("FAIL pair_time got=%0d want=%0d", dl_time, t_exp); else passed++;
        total++; if (state !== 2'b10) $display("FAIL pair_state got=%b want=10", state); else passed++;
        $display("pair: detect=%b kind=%b mask=%b origin=%0d time=%0d", dl_detect, dl_kind, dl_mask, dl_origin, dl_time);
    endtask

    task automatic test_mask_toggle();
        blk_out = 4'b0000; blk_in = 4'b0000;
        do_clear();
        threshold = 16'd8; blk_out = 4'b0010; blk_in = 4'b0100;
        step(4);
        blk_out = 4'b0001; blk_in = 4'b0010;
        for (int k = 5; k <= 12; k++) begin
            if (k == 12) t_exp = cyc;
            @(negedge clk);
            if (k == 11) begin
                total++; if (dl_detect !== 1'b0) $display("FAIL toggle_early got=%b want=0", dl_detect); else passed++;
            end
        end
        total++; if (dl_detect !== 1'b1) $display("FAIL toggle_detect got=%b want=1", dl_detect); else passed++;
        total++; if (dl_mask !== 3'b001) $display("FAIL toggle_mask got=%b want=001", dl_mask); else passed++;
        total++; if (dl_origin !== 2'd0) $display("FAIL toggle_origin got=%0d want=0", dl_origin); else passed++;
        total++; if (dl_time !== t_exp) $display("FAIL toggle_time got=%0d want=%0d", dl_time, t_exp); else passed++;
        $display("toggle: detect=%b mask=%b origin=%0d time=%0d", dl_detect, dl_mask, dl_origin, dl_time);
    endtask

    task automatic test_global();
        blk_out = 4'b0000; blk_in = 4'b0000;
        do_clear();
        threshold = 16'd3; blk_in = 4'b1111; blk_out = 4'b0000;
        step(2);
        total++; if ({dl_detect, state} !== 3'b001) $display("FAIL global_early got=%b want=001", {dl_detect, state}); else passed++;
        step(1);
        total++; if (dl_detect !== 1'b1) $display("FAIL global_detect got=%b want=1", dl_detect); else passed++;
        total++; if (dl_kind !== 2'b10) $display("FAIL global_kind got=%b want=10", dl_kind); else passed++;
        total++; if (dl_mask !== 3'b000) $display("FAIL global_mask got=%b want=000", dl_mask); else passed++;
        $display("global: detect=%b kind=%b mask=%b", dl_detect, dl_kind, dl_mask);
        blk_in = 4'b0000;
        do_clear();
        blk_in = 4'b1111; blk_out = 4'b0010;
        step(3);
        total++; if (dl_kind !== 2'b01) $display("FAIL tie_kind got=%b want=01", dl_kind); else passed++;
        total++; if (dl_mask !== 3'b010) $display("FAIL tie_mask got=%b want=010", dl_mask); else passed++;
        $display("tie: detect=%b kind=%b mask=%b", dl_detect, dl_kind, dl_mask);
    endtask

    task automatic test_clear_redetect();
        // Condition (blk_in=1111, blk_out=0010) is still held while detected.
        do_clear();
        total++; if ({dl_detect, dl_kind, dl_mask, dl_origin, dl_time, state} !== 42'd0)
            $display("FAIL clear_outputs got=%h want=0", {dl_detect, dl_kind, dl_mask, dl_origin, dl_time, state}); else passed++;
        step(2);
        total++; if (dl_detect !== 1'b0) $display("FAIL redetect_early got=%b want=0", dl_detect); else passed++;
        step(1);
        total++; if (dl_detect !== 1'b1) $display("FAIL redetect got=%b want=1", dl_detect); else passed++;
        $display("redetect: detect=%b kind=%b", dl_detect, dl_kind);
        do_clear();
        step(2);
        do_clear();
        total++; if ({dl_detect, state} !== 3'b000) $display("FAIL clear_wins got=%b want=000", {dl_detect, state}); else passed++;
        step(1);
        total++; if ({dl_detect, state} !== 3'b001) $display("FAIL after_clear_wins got=%b want=001", {dl_detect, state}); else passed++;
        $display("clear_wins: detect=%b state=%b", dl_detect, state);
    endtask

    task automatic test_enable_off();
        int bad;
        bad = 0;
        blk_in = 4'b0000; blk_out = 4'b0000;
        do_clear();
        enable = 1'b0; threshold = 16'd3; blk_out = 4'b0010; blk_in = 4'b0100;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (state !== 2'b00 || dl_detect !== 1'b0) bad++;
        end
        total++; if (bad !== 0) $display("FAIL enable_off bad_cycles=%0d want=0", bad); else passed++;
        $display("enable_off: state=%b detect=%b", state, dl_detect);
    endtask

    task automatic test_thr_zero();
        enable = 1'b1; threshold = 16'd0;
        step(1);
        total++; if ({dl_detect, dl_kind} !== 3'b101) $display("FAIL thr_zero got=%b want=101", {dl_detect, dl_kind}); else passed++;
        $display("thr_zero: detect=%b kind=%b", dl_detect, dl_kind);
    endtask

    task automatic test_thr_change();
        blk_in = 4'b0000; blk_out = 4'b0000;
        do_clear();
        threshold = 16'd10; blk_out = 4'b0010; blk_in = 4'b0100;
        step(5);
        total++; if ({dl_detect, state} !== 3'b001) $display("FAIL thr_change_armed got=%b want=001", {dl_detect, state}); else passed++;
        threshold = 16'd4;
        step(1);
        total++; if (dl_detect !== 1'b1) $display("FAIL thr_lowered got=%b want=1", dl_detect); else passed++;
        $display("thr_change: detect=%b state=%b", dl_detect, state);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; clear = 1'b0; threshold = 16'd0;
        blk_in = 4'b0000; blk_out = 4'b0000;
        step(2);
        test_reset();
        test_pair_detect();
        test_mask_toggle();
        test_global();
        test_clear_redetect();
        test_enable_off();
        test_thr_zero();
        test_thr_change();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
